mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns the latched load/store into a request/acknowledge transaction on the data-memory bus and holds the pipeline while that transaction is outstanding.
- Aligns and extends load data, and detects address-error and bus-timeout exceptions.
- Hands the result and the merged exception type to the MEM/WB register.

Parameters:
- TIMEOUT, 16: maximum REQ cycles to wait for dm_ack before a bus error is raised.
- EXC_ADEL, 32'h4: excepttype code for a misaligned load.
- EXC_ADES, 32'h5: excepttype code for a misaligned store.
- EXC_DBE, 32'h7: excepttype code for a data bus timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ext_stall  in  1  pipeline hold from all sources except this block (mem_stall must not feed back into it).
- cu_flush  in  1  kill the current MEM-stage instruction.
- mem_nop  in  1  MEM-stage slot is a bubble.
- exmem_mem_r  in  1  load.
- exmem_mem_w  in  1  store.
- exmem_alu_res  in  32  effective address.
- exmem_aligned_rt_data  in  32  store data, already lane-aligned.
- mem_byte_w_en_in  in  4  store byte lanes.
- exmem_load_sel  in  3  load type: 0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu, other values treated as lw.
- exmem_excepttype  in  32  exception type from earlier stages.
- dm_rdata  in  32  read data from memory.
- dm_ack  in  1  memory completes the request this cycle.
- dm_req  out  1  bus request.
- dm_we  out  1  write request.
- dm_addr  out  32  word address; low 2 bits forced to 0.
- dm_wdata  out  32  write data.
- dm_be  out  4  write byte enables.
- mem_stall  out  1  hold request to the control unit.
- mem_load_data  out  32  aligned and extended load result.
- mem_excepttype  out  32  merged exception type.
- mem_bad_vaddr  out  32  faulting address; 0 when no address fault.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, timeout counter=0.
  - dm_req, dm_we, dm_addr, dm_wdata, dm_be = 0.
  - mem_load_data = 0, captured exception = 0.
- access = (exmem_mem_r | exmem_mem_w) & !mem_nop & !cu_flush & (exmem_excepttype==0) & !misaligned.
- Misalignment:
  - Loads: lw needs addr[1:0]==0; lh/lhu need addr[0]==0.
  - Stores: be 4'b1111 needs addr[1:0]==0; be 4'b0011 or 4'b1100 needs addr[0]==0.
- Exception priority: exmem_excepttype != 0 passes through unchanged, then ADEL/ADES (mem_bad_vaddr = address), then DBE. Any exception suppresses the bus access. All exception outputs are combinational from the current inputs plus the captured DBE flag.
- States:
  - IDLE: mem_stall = access. If access: latch dm_addr, dm_wdata, dm_be, dm_we = exmem_mem_w, assert dm_req, go to REQ.
  - REQ: mem_stall=1; counter increments each cycle.
    - dm_ack: drop dm_req; capture dm_rdata; go to DONE.
    - No ack and counter reaches TIMEOUT-1: drop dm_req; set DBE flag; go to DONE.
    - cu_flush asserted: go to DRAIN.
  - DRAIN: mem_stall=1; dm_req held until dm_ack, then IDLE with data discarded. DRAIN does not time out, so a transaction is never abandoned mid-bus.
  - DONE: mem_stall=0; result and flag are held. On !ext_stall go to IDLE and clear the DBE flag. On cu_flush go to IDLE.
- Latency: a zero-wait memory gives 2 stall cycles (IDLE + REQ), with the result valid in DONE; each extra wait cycle adds 1.
- dm_req is never re-issued for the same instruction while ext_stall holds DONE.
- Load extension from the captured word, lane = addr[1:0]:
  - lb sign-extends the byte; lbu zero-extends it.
  - lh/lhu use lane addr[1]; lw passes through.
  - mem_load_data = 0 for stores and bubbles.
- Counter width is $clog2(TIMEOUT)+1; it resets to 0 on entry to REQ.

Decomposition:
- Shared package: exception codes, load_sel encodings, the FSM state encoding (IDLE, REQ, DRAIN, DONE).
- One sub-module: load_aligner, combinational. Inputs word, addr[1:0], load_sel; output 32-bit extended data.

Test Plan:
- lb at 0x1003, dm_rdata 0x80FF_FF7F, ack on the first REQ cycle → dm_req high 1 cycle, mem_stall high 2 cycles, mem_load_data 0xFFFF_FF80.
- sw at 0x2000, data 0xDEADBEEF, be 1111, ack after 3 wait cycles → dm_we=1, dm_addr 0x2000, mem_stall high 5 cycles, mem_excepttype 0.
- lh at 0x3001 → no dm_req, mem_stall 0, mem_excepttype 0x4, mem_bad_vaddr 0x3001.
- lw with no ack for TIMEOUT=16 cycles → dm_req drops after 16 REQ cycles, mem_excepttype 0x7, mem_stall falls.
- cu_flush in the second REQ cycle, ack 2 cycles later → DRAIN holds dm_req until ack, result discarded, then IDLE with mem_load_data 0.
- reset asserted mid-REQ → dm_req and mem_stall drop immediately; state IDLE; next lhu at 0x4002 with rdata 0x8001_0000 → mem_load_data 0x0000_8001.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
//   Shared definitions for the MEM-stage data-memory access unit:
//   default exception codes, load-type encodings carried on exmem_load_sel,
//   and the encoding of the bus-transaction state machine.
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

  // Default excepttype codes reported by the MEM stage.
  localparam logic [31:0] EXC_ADEL_DEF = 32'h0000_0004;  // misaligned load
  localparam logic [31:0] EXC_ADES_DEF = 32'h0000_0005;  // misaligned store
  localparam logic [31:0] EXC_DBE_DEF  = 32'h0000_0007;  // data bus timeout

  // Load types on exmem_load_sel. Encodings not listed behave as LD_LW.
  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LB  = 3'd1,
    LD_LBU = 3'd2,
    LD_LH  = 3'd3,
    LD_LHU = 3'd4
  } load_sel_e;

  // Bus transaction state.
  //   S_IDLE  : waiting for a valid load/store in the MEM slot
  //   S_REQ   : dm_req raised, waiting for dm_ack or the timeout
  //   S_DRAIN : instruction was flushed mid-request; finish the bus cycle
  //   S_DONE  : result/flag held until the pipeline advances
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit_load_aligner.sv
// -----------------------------------------------------------------------------
// mem_access_unit_load_aligner
//   Combinational lane select and sign/zero extension of a loaded word.
//
//   Ports
//     word     in  32  word returned by data memory
//     addr_lo  in  2   byte offset of the load within the word
//     load_sel in  3   load type (see load_sel_e); unknown codes act as lw
//     data     out 32  aligned, extended load result
// -----------------------------------------------------------------------------
module mem_access_unit_load_aligner
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_sel,
  output logic [31:0] data
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0]  bs;
    logic signed [31:0] ws;
    bs = b;
    ws = bs;  // signed-to-signed assignment replicates bit 7
    return sgn ? ws : {24'd0, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0] hs;
    logic signed [31:0] ws;
    hs = h;
    ws = hs;
    return sgn ? ws : {16'd0, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    data     = word;
    case (load_sel_e'(load_sel))
      LD_LB:   data = ext_byte(byte_sel, 1'b1);
      LD_LBU:  data = ext_byte(byte_sel, 1'b0);
      LD_LH:   data = ext_half(half_sel, 1'b1);
      LD_LHU:  data = ext_half(half_sel, 1'b0);
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   MEM-stage consumer of the EX/MEM register. Converts the latched load or
//   store into a req/ack transaction on the data-memory bus, stalls the
//   pipeline while it is outstanding, aligns/extends load data, and merges
//   address-error and bus-timeout exceptions into the excepttype handed to
//   the MEM/WB register.
//
//   Ports
//     clk, reset (async, active-low)
//     ext_stall               hold from every other source (not mem_stall)
//     cu_flush, mem_nop       kill / bubble qualifiers for the MEM slot
//     exmem_mem_r/_mem_w      load / store
//     exmem_alu_res           effective address
//     exmem_aligned_rt_data   store data, lane-aligned
//     mem_byte_w_en_in        store byte lanes
//     exmem_load_sel          load type
//     exmem_excepttype        exception from earlier stages
//     dm_rdata, dm_ack        memory response
//     dm_req, dm_we, dm_addr, dm_wdata, dm_be   memory request
//     mem_stall               hold request to the control unit
//     mem_load_data           aligned load result (0 for stores/bubbles)
//     mem_excepttype          merged exception type
//     mem_bad_vaddr           faulting address on ADEL/ADES, else 0
// -----------------------------------------------------------------------------
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] EXC_ADEL = EXC_ADEL_DEF,
  parameter logic [31:0] EXC_ADES = EXC_ADES_DEF,
  parameter logic [31:0] EXC_DBE  = EXC_DBE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_stall,
  input  logic        cu_flush,
  input  logic        mem_nop,
  input  logic        exmem_mem_r,
  input  logic        exmem_mem_w,
  input  logic [31:0] exmem_alu_res,
  input  logic [31:0] exmem_aligned_rt_data,
  input  logic [3:0]  mem_byte_w_en_in,
  input  logic [2:0]  exmem_load_sel,
  input  logic [31:0] exmem_excepttype,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  output logic        mem_stall,
  output logic [31:0] mem_load_data,
  output logic [31:0] mem_excepttype,
  output logic [31:0] mem_bad_vaddr
);

  localparam int                CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  mau_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt;

  // Fields latched when the request is issued, and the captured response.
  logic              ld_p1;
  logic [1:0]        addr_lo_p1;
  logic [2:0]        load_sel_p1;
  logic [31:0]       rdata_p1;
  logic              dbe_p1;

  logic              ld_mis, st_mis;
  logic              adel, ades, access;
  logic              start, capture, req_off, set_dbe, clr_dbe;
  logic [31:0]       aligned;

  // ---------------------------------------------------------------------------
  // Address checks and request qualification on the current EX/MEM fields.
  // ---------------------------------------------------------------------------
  always_comb begin
    ld_mis = 1'b0;
    case (load_sel_e'(exmem_load_sel))
      LD_LB, LD_LBU: ld_mis = 1'b0;
      LD_LH, LD_LHU: ld_mis = exmem_alu_res[0];
      default:       ld_mis = |exmem_alu_res[1:0];
    endcase

    st_mis = 1'b0;
    case (mem_byte_w_en_in)
      4'b1111:          st_mis = |exmem_alu_res[1:0];
      4'b0011, 4'b1100: st_mis = exmem_alu_res[0];
      default:          st_mis = 1'b0;
    endcase
  end

  // A bubble carries no real access, so it cannot fault on its address.
  assign adel   = ~mem_nop & exmem_mem_r & ld_mis;
  assign ades   = ~mem_nop & exmem_mem_w & st_mis;
  assign access = (exmem_mem_r | exmem_mem_w) & ~mem_nop & ~cu_flush &
                  (exmem_excepttype == 32'd0) & ~(adel | ades);

  // ---------------------------------------------------------------------------
  // Transaction FSM: next state, stall and register-update strobes.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    start     = 1'b0;
    capture   = 1'b0;
    req_off   = 1'b0;
    set_dbe   = 1'b0;
    clr_dbe   = 1'b0;
    case (state)
      S_IDLE: begin
        // Gating with reset keeps the stall low while reset is held even
        // though the EX/MEM fields may still describe a valid access.
        mem_stall = access & reset;
        if (access) begin
          start     = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        mem_stall = 1'b1;
        if (dm_ack) begin
          // A flush coinciding with the ack has nothing left to drain.
          req_off = 1'b1;
          if (cu_flush) begin
            state_nxt = S_IDLE;
          end else begin
            capture   = 1'b1;
            state_nxt = S_DONE;
          end
        end else if (cu_flush) begin
          state_nxt = S_DRAIN;
        end else if (cnt == CNT_LAST) begin
          req_off   = 1'b1;
          set_dbe   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DRAIN: begin
        // No timeout here: the bus cycle is always allowed to complete.
        mem_stall = 1'b1;
        if (dm_ack) begin
          req_off   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        if (!ext_stall || cu_flush) begin
          clr_dbe   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request / response registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= 32'd0;
      dm_wdata    <= 32'd0;
      dm_be       <= 4'd0;
      ld_p1       <= 1'b0;
      addr_lo_p1  <= 2'd0;
      load_sel_p1 <= 3'd0;
      rdata_p1    <= 32'd0;
      dbe_p1      <= 1'b0;
    end else begin
      state <= state_nxt;

      if (start) begin
        dm_req      <= 1'b1;
        dm_we       <= exmem_mem_w;
        dm_addr     <= {exmem_alu_res[31:2], 2'b00};
        dm_wdata    <= exmem_aligned_rt_data;
        dm_be       <= mem_byte_w_en_in;
        ld_p1       <= exmem_mem_r & ~exmem_mem_w;
        addr_lo_p1  <= exmem_alu_res[1:0];
        load_sel_p1 <= exmem_load_sel;
        cnt         <= '0;
      end else if (state == S_REQ) begin
        cnt <= cnt + 1'b1;
      end

      if (req_off) begin
        dm_req <= 1'b0;
        dm_we  <= 1'b0;
      end

      if (capture) begin
        rdata_p1 <= dm_rdata;
      end

      if (set_dbe) begin
        dbe_p1 <= 1'b1;
      end else if (clr_dbe) begin
        dbe_p1 <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result and exception merge.
  // ---------------------------------------------------------------------------
  mem_access_unit_load_aligner u_load_aligner (
    .word     (rdata_p1),
    .addr_lo  (addr_lo_p1),
    .load_sel (load_sel_p1),
    .data     (aligned)
  );

  // Load data is only meaningful while a completed load sits in DONE; a
  // timed-out load never captured a word, so it reports 0.
  assign mem_load_data = (state == S_DONE && ld_p1 && !dbe_p1) ? aligned : 32'd0;

  always_comb begin
    mem_excepttype = 32'd0;
    mem_bad_vaddr  = 32'd0;
    if (exmem_excepttype != 32'd0) begin
      mem_excepttype = exmem_excepttype;
    end else if (adel) begin
      mem_excepttype = EXC_ADEL;
      mem_bad_vaddr  = exmem_alu_res;
    end else if (ades) begin
      mem_excepttype = EXC_ADES;
      mem_bad_vaddr  = exmem_alu_res;
    end else if (dbe_p1) begin
      mem_excepttype = EXC_DBE;
    end
  end

endmodule
